// File: rtl/seq_det_pkg.sv
// Shared defaults and width helper for the parameterised serial sequence detector.
package seq_det_pkg;

  localparam int unsigned DEF_PAT_W   = 4;
  localparam int unsigned DEF_CNT_W   = 8;
  localparam logic [3:0]  DEF_PAT_RST = 4'b1011;

  // Width of the prefix-length output; never narrower than one bit.
  function automatic int unsigned state_w(input int unsigned pat_w);
    return ($clog2(pat_w) < 1) ? 1 : $clog2(pat_w);
  endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// Combinational longest-prefix finder: how many of the newest history bits
// already match the start of the pattern.
module seq_prefix_match
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W,
  parameter int unsigned SW    = state_w(DEF_PAT_W)
) (
  input  logic [PAT_W-2:0] hist,
  input  logic [SW-1:0]    fill,
  input  logic [PAT_W-1:0] pat,
  output logic [SW-1:0]    state
);

  logic [PAT_W-2:0] mask;
  logic [PAT_W-2:0] pat_top;

  // Ascending scan so the largest matching length wins.
  always_comb begin
    state   = '0;
    mask    = '0;
    pat_top = '0;
    for (int unsigned k = 1; k < PAT_W; k++) begin
      mask    = {(PAT_W-1){1'b1}} >> (PAT_W - 1 - k);
      pat_top = (PAT_W-1)'(pat >> (PAT_W - k));
      if ((fill >= SW'(k)) && ((hist & mask) == (pat_top & mask))) begin
        state = SW'(k);
      end
    end
  end

endmodule

// File: rtl/param_seq_detector.sv
// Serial pattern detector with runtime-loadable pattern, overlap mode,
// Mealy match flag and saturating match counter.
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned         PAT_W   = DEF_PAT_W,
  parameter int unsigned         CNT_W   = DEF_CNT_W,
  parameter logic [PAT_W-1:0]    PAT_RST = PAT_W'(DEF_PAT_RST)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in,
  input  logic                        in_valid,
  input  logic                        cfg_load,
  input  logic [PAT_W-1:0]            cfg_pat,
  input  logic                        cfg_overlap,
  input  logic                        cnt_clr,
  output logic                        dec,
  output logic [state_w(PAT_W)-1:0]   state,
  output logic [CNT_W-1:0]            match_cnt
);

  localparam int unsigned      SW       = state_w(PAT_W);
  localparam logic [SW-1:0]    FILL_MAX = SW'(PAT_W - 1);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic             ovl_q, ovl_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [SW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  // Gating on rst_n keeps the flag quiet for the whole reset cycle.
  assign dec = rst_n & in_valid & ~cfg_load & (fill_q == FILL_MAX) &
               ({hist_q, in} == pat_q);

  always_comb begin
    pat_d       = pat_q;
    ovl_d       = ovl_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    match_cnt_d = match_cnt_q;

    if (cfg_load) begin
      pat_d  = cfg_pat;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      if (dec && !ovl_q) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = (PAT_W-1)'({hist_q, in});
        if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
      end
    end

    if (cnt_clr) begin
      match_cnt_d = '0;
    end else if (dec && (match_cnt_q != '1)) begin
      match_cnt_d = match_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q       <= PAT_RST;
      ovl_q       <= 1'b1;
      hist_q      <= '0;
      fill_q      <= '0;
      match_cnt_q <= '0;
    end else begin
      pat_q       <= pat_d;
      ovl_q       <= ovl_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  seq_prefix_match #(
    .PAT_W (PAT_W),
    .SW    (SW)
  ) u_prefix (
    .hist  (hist_q),
    .fill  (fill_q),
    .pat   (pat_q),
    .state (state)
  );

  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_param_seq_detector.sv
// Directed bench for param_seq_detector: default, 6-bit pattern and 2-bit counter instances.
module tb_param_seq_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: defaults
  logic       rst_n_a, in_a, in_valid_a, cfg_load_a, cfg_overlap_a, cnt_clr_a, dec_a;
  logic [3:0] cfg_pat_a;
  logic [1:0] state_a;
  logic [7:0] match_cnt_a;

  // Instance B: 6-bit pattern
  logic       rst_n_b, in_b, in_valid_b, cfg_load_b, cfg_overlap_b, cnt_clr_b, dec_b;
  logic [5:0] cfg_pat_b;
  logic [2:0] state_b;
  logic [7:0] match_cnt_b;

  // Instance C: 2-bit counter
  logic       rst_n_c, in_c, in_valid_c, cfg_load_c, cfg_overlap_c, cnt_clr_c, dec_c;
  logic [3:0] cfg_pat_c;
  logic [1:0] state_c;
  logic [1:0] match_cnt_c;

  param_seq_detector u_a (
    .clk(clk), .rst_n(rst_n_a), .in(in_a), .in_valid(in_valid_a), .cfg_load(cfg_load_a),
    .cfg_pat(cfg_pat_a), .cfg_overlap(cfg_overlap_a), .cnt_clr(cnt_clr_a),
    .dec(dec_a), .state(state_a), .match_cnt(match_cnt_a)
  );

  param_seq_detector #(.PAT_W(6), .CNT_W(8), .PAT_RST(6'b000111)) u_b (
    .clk(clk), .rst_n(rst_n_b), .in(in_b), .in_valid(in_valid_b), .cfg_load(cfg_load_b),
    .cfg_pat(cfg_pat_b), .cfg_overlap(cfg_overlap_b), .cnt_clr(cnt_clr_b),
    .dec(dec_b), .state(state_b), .match_cnt(match_cnt_b)
  );

  param_seq_detector #(.CNT_W(2)) u_c (
    .clk(clk), .rst_n(rst_n_c), .in(in_c), .in_valid(in_valid_c), .cfg_load(cfg_load_c),
    .cfg_pat(cfg_pat_c), .cfg_overlap(cfg_overlap_c), .cnt_clr(cnt_clr_c),
    .dec(dec_c), .state(state_c), .match_cnt(match_cnt_c)
  );

  // ---------------- stimulus drivers ----------------
  task automatic send_a(input logic b, output logic d);
    @(negedge clk);
    in_a = b; in_valid_a = 1'b1;
    #1 d = dec_a;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
  endtask

  task automatic load_a(input logic [3:0] p, input logic ovl, input logic v, input logic b,
                        output logic d);
    @(negedge clk);
    cfg_load_a = 1'b1; cfg_pat_a = p; cfg_overlap_a = ovl; in_valid_a = v; in_a = b;
    #1 d = dec_a;
    @(posedge clk); #1;
    cfg_load_a = 1'b0; in_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic b, output logic d);
    @(negedge clk);
    in_b = b; in_valid_b = 1'b1;
    #1 d = dec_b;
    @(posedge clk); #1;
    in_valid_b = 1'b0;
  endtask

  task automatic send_c(input logic b, input logic clr, output logic d);
    @(negedge clk);
    in_c = b; in_valid_c = 1'b1; cnt_clr_c = clr;
    #1 d = dec_c;
    @(posedge clk); #1;
    in_valid_c = 1'b0; cnt_clr_c = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
    in_a = 1'b1; in_valid_a = 1'b1; cfg_load_a = 1'b1; cfg_pat_a = 4'b0000; cnt_clr_a = 1'b1;
    #1;
    n_checks++;
    if (dec_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_dec: got %b expected 0", dec_a);
    end
    @(posedge clk); #1;
    rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
    in_valid_a = 1'b0; cfg_load_a = 1'b0; cnt_clr_a = 1'b0;
    n_checks++;
    if (state_a !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", state_a);
    end
    n_checks++;
    if (match_cnt_a !== 8'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d expected 0", match_cnt_a);
    end
  endtask

  task automatic test_overlap();
    logic [15:0] s;
    logic [15:0] got;
    logic d;
    s = 16'b0111011011010100;
    got = '0;
    for (int i = 0; i < 16; i++) begin
      send_a(s[15-i], d);
      got[i] = d;
      if (i == 5) begin
        n_checks++;
        if (state_a !== 2'd3) begin
          n_fail++; $display("FAIL ovl_state5: got %0d expected 3", state_a);
        end
      end
    end
    n_checks++;
    if (got !== 16'h0240) begin
      n_fail++; $display("FAIL ovl_dec_mask: got %h expected 0240", got);
    end
    n_checks++;
    if (match_cnt_a !== 8'd2) begin
      n_fail++; $display("FAIL ovl_cnt: got %0d expected 2", match_cnt_a);
    end
  endtask

  task automatic test_load_discard();
    logic d;
    send_a(1'b1, d); send_a(1'b0, d); send_a(1'b1, d);
    load_a(4'b1011, 1'b0, 1'b1, 1'b1, d);
    n_checks++;
    if (d !== 1'b0) begin
      n_fail++; $display("FAIL load_dec: got %b expected 0", d);
    end
    n_checks++;
    if (state_a !== 2'd0) begin
      n_fail++; $display("FAIL load_state: got %0d expected 0", state_a);
    end
    n_checks++;
    if (match_cnt_a !== 8'd2) begin
      n_fail++; $display("FAIL load_cnt_hold: got %0d expected 2", match_cnt_a);
    end
  endtask

  task automatic test_nonoverlap();
    logic [15:0] s;
    logic [15:0] got;
    logic d;
    @(negedge clk); cnt_clr_a = 1'b1;
    @(posedge clk); #1; cnt_clr_a = 1'b0;
    n_checks++;
    if (match_cnt_a !== 8'd0) begin
      n_fail++; $display("FAIL clr_cnt: got %0d expected 0", match_cnt_a);
    end
    s = 16'b0111011011010100;
    got = '0;
    for (int i = 0; i < 16; i++) begin
      send_a(s[15-i], d);
      got[i] = d;
    end
    n_checks++;
    if (got !== 16'h0040) begin
      n_fail++; $display("FAIL novl_dec_mask: got %h expected 0040", got);
    end
    n_checks++;
    if (match_cnt_a !== 8'd1) begin
      n_fail++; $display("FAIL novl_cnt: got %0d expected 1", match_cnt_a);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] p;
    logic [1:0] exp_st [4];
    logic d;
    int pulses;
    p = 4'b1011;
    exp_st = '{2'd1, 2'd2, 2'd3, 2'd1};
    pulses = 0;
    load_a(4'b1011, 1'b1, 1'b0, 1'b0, d);
    for (int j = 0; j < 4; j++) begin
      send_a(p[3-j], d);
      if (d === 1'b1) pulses++;
      n_checks++;
      if (state_a !== exp_st[j]) begin
        n_fail++; $display("FAIL gap_state_bit%0d: got %0d expected %0d", j, state_a, exp_st[j]);
      end
      if (j < 3) begin
        @(negedge clk); in_valid_a = 1'b0; in_a = 1'b1;
        #1;
        if (dec_a === 1'b1) pulses++;
        @(posedge clk); #1;
        n_checks++;
        if (state_a !== exp_st[j]) begin
          n_fail++; $display("FAIL gap_hold%0d: got %0d expected %0d", j, state_a, exp_st[j]);
        end
      end
    end
    n_checks++;
    if (pulses != 1 || d !== 1'b1) begin
      n_fail++; $display("FAIL gap_pulses: got %0d last=%b expected 1 last=1", pulses, d);
    end
    n_checks++;
    if (match_cnt_a !== 8'd2) begin
      n_fail++; $display("FAIL gap_cnt: got %0d expected 2", match_cnt_a);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] s;
    logic [3:0] got;
    logic d;
    send_a(1'b1, d); send_a(1'b0, d); send_a(1'b1, d);
    n_checks++;
    if (state_a !== 2'd3) begin
      n_fail++; $display("FAIL rmid_pre_state: got %0d expected 3", state_a);
    end
    @(negedge clk);
    rst_n_a = 1'b0; in_a = 1'b1; in_valid_a = 1'b1;
    #1;
    n_checks++;
    if (dec_a !== 1'b0) begin
      n_fail++; $display("FAIL rmid_dec: got %b expected 0", dec_a);
    end
    @(posedge clk); #1;
    rst_n_a = 1'b1; in_valid_a = 1'b0;
    n_checks++;
    if (state_a !== 2'd0 || match_cnt_a !== 8'd0) begin
      n_fail++; $display("FAIL rmid_post: got state=%0d cnt=%0d expected 0 0", state_a, match_cnt_a);
    end
    send_a(1'b1, d);
    n_checks++;
    if (d !== 1'b0 || state_a !== 2'd1) begin
      n_fail++; $display("FAIL rmid_one: got dec=%b state=%0d expected 0 1", d, state_a);
    end
    s = 4'b1011;
    got = '0;
    for (int j = 0; j < 4; j++) begin
      send_a(s[3-j], d);
      got[j] = d;
    end
    n_checks++;
    if (got !== 4'b1000 || match_cnt_a !== 8'd1) begin
      n_fail++; $display("FAIL rmid_full: got mask=%b cnt=%0d expected 1000 1", got, match_cnt_a);
    end
  endtask

  task automatic test_pat6();
    logic [8:0] s;
    logic [8:0] got;
    logic d;
    @(negedge clk);
    cfg_load_b = 1'b1; cfg_pat_b = 6'b110110; cfg_overlap_b = 1'b1;
    @(posedge clk); #1; cfg_load_b = 1'b0;
    s = 9'b110110110;
    got = '0;
    for (int i = 0; i < 9; i++) begin
      send_b(s[8-i], d);
      got[i] = d;
      if (i == 5) begin
        n_checks++;
        if (state_b !== 3'd3) begin
          n_fail++; $display("FAIL p6_state5: got %0d expected 3", state_b);
        end
      end
    end
    n_checks++;
    if (got !== 9'h120) begin
      n_fail++; $display("FAIL p6_dec_mask: got %h expected 120", got);
    end
    n_checks++;
    if (match_cnt_b !== 8'd2) begin
      n_fail++; $display("FAIL p6_cnt: got %0d expected 2", match_cnt_b);
    end
  endtask

  task automatic test_saturate();
    logic [15:0] s;
    logic [15:0] got;
    logic d;
    s = 16'b1011011011011011;
    got = '0;
    for (int i = 0; i < 16; i++) begin
      send_c(s[15-i], 1'b0, d);
      got[i] = d;
      if (i == 3) begin
        n_checks++;
        if (match_cnt_c !== 2'd1) begin
          n_fail++; $display("FAIL sat_cnt1: got %0d expected 1", match_cnt_c);
        end
      end
      if (i == 9 || i == 15) begin
        n_checks++;
        if (match_cnt_c !== 2'd3) begin
          n_fail++; $display("FAIL sat_cnt_bit%0d: got %0d expected 3", i, match_cnt_c);
        end
      end
    end
    n_checks++;
    if (got !== 16'h9248) begin
      n_fail++; $display("FAIL sat_dec_mask: got %h expected 9248", got);
    end
    send_c(1'b0, 1'b0, d);
    send_c(1'b1, 1'b0, d);
    send_c(1'b1, 1'b1, d);
    n_checks++;
    if (d !== 1'b1 || match_cnt_c !== 2'd0) begin
      n_fail++; $display("FAIL clr_on_match: got dec=%b cnt=%0d expected 1 0", d, match_cnt_c);
    end
  endtask

  initial begin
    rst_n_a = 1'b0; in_a = 1'b0; in_valid_a = 1'b0; cfg_load_a = 1'b0;
    cfg_pat_a = '0; cfg_overlap_a = 1'b0; cnt_clr_a = 1'b0;
    rst_n_b = 1'b0; in_b = 1'b0; in_valid_b = 1'b0; cfg_load_b = 1'b0;
    cfg_pat_b = '0; cfg_overlap_b = 1'b0; cnt_clr_b = 1'b0;
    rst_n_c = 1'b0; in_c = 1'b0; in_valid_c = 1'b0; cfg_load_c = 1'b0;
    cfg_pat_c = '0; cfg_overlap_c = 1'b0; cnt_clr_c = 1'b0;

    test_reset();
    test_overlap();
    test_load_discard();
    test_nonoverlap();
    test_gaps();
    test_reset_mid();
    test_pat6();
    test_saturate();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
